lab4_branch_branch_gshare: RTL

LAB4_BRANCH_BRANCH_GSHARE -- requirements
Module: lab4_branch_branch_gshare

---
 rtl/lab4_branch_branch_gshare.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/lab4_branch_branch_gshare.sv
`default_nettype none
// ============================================================================
//  Module   : lab4_branch_branch_gshare
//  Purpose  : Gshare branch direction predictor. A pattern-history table of
//             saturating counters is indexed by PC[IDX+1:2] XOR the global
//             history register. After reset, an init sweep writes every entry
//             to weakly not-taken. Lookups are ready once the sweep is done.
//  Ports    : clk         - clock, rising edge
//             reset       - asynchronous reset, active low
//             PC          - lookup address
//             prediction  - 1 = predicted taken (0 while not ready)
//             pred_ghr    - GHR used for this lookup (return it on update)
//             ready       - table initialised, lookups/updates valid
//             update_en   - commit a resolved branch this cycle
//             update_val  - resolved outcome, 1 = taken
//             update_pc   - address of the resolved branch
//             update_ghr  - pred_ghr snapshot captured at prediction time
//  Config   : `define LAB4_BRANCH_GSHARE_BYPASS_EN to forward a same-cycle
//             update into the lookup when both hit the same index.
//  Revision : 1.0 - initial release
// ============================================================================
module lab4_branch_branch_gshare #(
   parameter int PHT_SIZE  = 2048,
   parameter int CTR_NBITS = 2,
   parameter int GHR_NBITS = 11
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          PC,
   output logic                 prediction,
   output logic [GHR_NBITS-1:0] pred_ghr,
   output logic                 ready,
   input  logic                 update_en,
   input  logic                 update_val,
   input  logic [31:0]          update_pc,
   input  logic [GHR_NBITS-1:0] update_ghr
);

   localparam int                   IDX        = $clog2(PHT_SIZE);
   localparam logic [CTR_NBITS-1:0] CTR_INIT   = CTR_NBITS'((1 << (CTR_NBITS - 1)) - 1);
   localparam logic [CTR_NBITS-1:0] CTR_MAX    = '1;
   localparam logic [IDX-1:0]       SWEEP_LAST = IDX'(PHT_SIZE - 1);

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                state, state_next;
   logic [IDX-1:0]        sweep_ptr, sweep_ptr_next;
   logic [GHR_NBITS-1:0]  ghr, ghr_next, ghr_shift;

   // Counter storage: no reset, contents are defined solely by the sweep.
   logic [CTR_NBITS-1:0]  pht [PHT_SIZE];

   logic [IDX-1:0]        lookup_idx, upd_idx, pht_waddr;
   logic [CTR_NBITS-1:0]  upd_old, upd_new, lookup_ctr, pht_wdata;
   logic                  pht_we, upd_active;

   // Address bits outside the index field do not take part in prediction.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{PC[31:IDX+2], PC[1:0], update_pc[31:IDX+2], update_pc[1:0]};

   assign lookup_idx = PC[IDX+1:2] ^ IDX'(ghr);
   assign upd_idx    = update_pc[IDX+1:2] ^ IDX'(update_ghr);
   assign upd_active = (state == RUN) && update_en;
   assign pred_ghr   = ghr;

   generate
      if (GHR_NBITS == 1) begin : g_ghr_single
         assign ghr_shift = update_val;
      end else begin : g_ghr_shift
         assign ghr_shift = {ghr[GHR_NBITS-2:0], update_val};
      end
   endgenerate

   // Read-modify-write of the update entry; a back-to-back update to the same
   // index reads the value written on the previous edge.
   always_comb begin
      upd_old = pht[upd_idx];
      upd_new = upd_old;
      if (update_val) begin
         if (upd_old != CTR_MAX) upd_new = upd_old + 1'b1;
      end else begin
         if (upd_old != '0) upd_new = upd_old - 1'b1;
      end
   end

   always_comb begin
      lookup_ctr = pht[lookup_idx];
`ifdef LAB4_BRANCH_GSHARE_BYPASS_EN
      if (upd_active && (upd_idx == lookup_idx)) lookup_ctr = upd_new;
`endif
      prediction = ready & lookup_ctr[CTR_NBITS-1];
   end

   // Next-state / output logic. The single PHT write port is shared between
   // the init sweep and committed updates, which never overlap in time.
   always_comb begin
      state_next     = state;
      sweep_ptr_next = sweep_ptr;
      ghr_next       = ghr;
      pht_we         = 1'b0;
      pht_waddr      = upd_idx;
      pht_wdata      = upd_new;
      ready          = 1'b0;
      case (state)
         INIT: begin
            pht_we         = 1'b1;
            pht_waddr      = sweep_ptr;
            pht_wdata      = CTR_INIT;
            // Pointer wraps back to 0 naturally since PHT_SIZE is a power of two.
            sweep_ptr_next = sweep_ptr + 1'b1;
            if (sweep_ptr == SWEEP_LAST) state_next = RUN;
         end
         RUN: begin
            ready = 1'b1;
            if (update_en) begin
               pht_we   = 1'b1;
               ghr_next = ghr_shift;
            end
         end
         default: state_next = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= INIT;
         sweep_ptr <= '0;
         ghr       <= '0;
      end else begin
         state     <= state_next;
         sweep_ptr <= sweep_ptr_next;
         ghr       <= ghr_next;
      end
   end

   always_ff @(posedge clk) begin
      if (pht_we) pht[pht_waddr] <= pht_wdata;
   end

endmodule
`default_nettype wire
